// File: rtl/inst_mem_sync_if.sv
// rtl/inst_mem_sync_if.sv - fetch and program-load signal bundle for inst_mem_sync
interface inst_mem_sync_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic                  if_stall;
    logic                  if_flush;
    logic [31:0]           if_pc;
    logic [DATA_WIDTH-1:0] if_inst;
    logic                  if_valid;
    logic                  if_fault;
    logic                  if_par_err;
    logic                  ld_start;
    logic                  ld_valid;
    logic                  ld_last;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_ready;
    logic                  ld_done;
    logic [ADDR_WIDTH:0]   ld_count;
    logic                  busy;

    modport master (
        output if_req, if_stall, if_flush, if_pc,
        output ld_start, ld_valid, ld_last, ld_data,
        input  if_inst, if_valid, if_fault, if_par_err,
        input  ld_ready, ld_done, ld_count, busy
    );

    modport slave (
        input  if_req, if_stall, if_flush, if_pc,
        input  ld_start, ld_valid, ld_last, ld_data,
        output if_inst, if_valid, if_fault, if_par_err,
        output ld_ready, ld_done, ld_count, busy
    );
endinterface

// File: rtl/inst_mem_sync.sv
// rtl/inst_mem_sync.sv - sync-read instruction memory with registered fetch port and sequential load FSM
// Optional word parity enabled by defining INSTMEM_PARITY_EN.
module inst_mem_sync #(
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h00000013
) (
    input  logic           clk,
    input  logic           rst_n,
    inst_mem_sync_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef INSTMEM_PARITY_EN
    localparam int                MEM_W     = DATA_WIDTH + 1;
    localparam logic [MEM_W-1:0] INIT_WORD = {^NOP_WORD, NOP_WORD};
`else
    localparam int                MEM_W     = DATA_WIDTH;
    localparam logic [MEM_W-1:0] INIT_WORD = NOP_WORD;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   ld_count_q, ld_count_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic                  valid_q, valid_d;
    logic                  fault_q, fault_d;
    logic                  par_err_q, par_err_d;

    // Array starts out as all bubbles so fetches before any load are harmless.
    logic [MEM_W-1:0] mem [DEPTH] = '{default: INIT_WORD};

    logic                  ld_fire;
    logic                  last_slot;
    logic [ADDR_WIDTH-1:0] wr_index;
    logic [ADDR_WIDTH-1:0] rd_index;
    logic [MEM_W-1:0]      wr_word;
    logic [MEM_W-1:0]      rd_word;
    logic                  pc_fault;
    logic                  par_bad;

    assign ld_fire   = (state_q == S_LOAD) && bus.ld_valid;
    assign wr_index  = ld_count_q[ADDR_WIDTH-1:0];
    assign last_slot = (ld_count_q == (ADDR_WIDTH + 1)'(DEPTH - 1));
    assign rd_index  = bus.if_pc[ADDR_WIDTH+1:2];
    assign rd_word   = mem[rd_index];
    assign pc_fault  = (|bus.if_pc[1:0]) || (|bus.if_pc[31:ADDR_WIDTH+2]);

`ifdef INSTMEM_PARITY_EN
    assign wr_word = {^bus.ld_data, bus.ld_data};
    assign par_bad = (^rd_word[DATA_WIDTH-1:0]) != rd_word[DATA_WIDTH];
`else
    assign wr_word = bus.ld_data;
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (ld_fire) begin
            mem[wr_index] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ld_count_q <= '0;
            inst_q     <= NOP_WORD;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_count_q <= ld_count_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            par_err_q  <= par_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ld_count_d = ld_count_q;
        case (state_q)
            S_IDLE: begin
                if (bus.ld_start) begin
                    state_d    = S_LOAD;
                    ld_count_d = '0;
                end
            end
            S_LOAD: begin
                if (bus.ld_valid) begin
                    ld_count_d = ld_count_q + 1'b1;
                    // Stopping at the top slot keeps the write index from wrapping.
                    if (bus.ld_last || last_slot) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A starting load owns the cycle, so a coincident fetch becomes a bubble.
    always_comb begin
        inst_d    = inst_q;
        valid_d   = valid_q;
        fault_d   = fault_q;
        par_err_d = par_err_q;
        if (bus.if_flush || (state_q != S_IDLE) || bus.ld_start) begin
            inst_d    = NOP_WORD;
            valid_d   = 1'b0;
            fault_d   = 1'b0;
            par_err_d = 1'b0;
        end else if (bus.if_stall) begin
            inst_d = inst_q;
        end else if (!bus.if_req) begin
            inst_d    = NOP_WORD;
            valid_d   = 1'b0;
            fault_d   = 1'b0;
            par_err_d = 1'b0;
        end else if (pc_fault || par_bad) begin
            inst_d    = NOP_WORD;
            valid_d   = 1'b1;
            fault_d   = 1'b1;
            par_err_d = !pc_fault && par_bad;
        end else begin
            inst_d    = rd_word[DATA_WIDTH-1:0];
            valid_d   = 1'b1;
            fault_d   = 1'b0;
            par_err_d = 1'b0;
        end
    end

    assign bus.if_inst    = inst_q;
    assign bus.if_valid   = valid_q;
    assign bus.if_fault   = fault_q;
    assign bus.if_par_err = par_err_q;
    assign bus.ld_ready   = (state_q == S_LOAD);
    assign bus.busy       = (state_q == S_LOAD);
    assign bus.ld_done    = (state_q == S_DONE);
    assign bus.ld_count   = ld_count_q;
endmodule

// File: tb/tb_inst_mem_sync.sv
// tb/tb_inst_mem_sync.sv - self-checking bench for inst_mem_sync with a behavioural reference model
module tb_inst_mem_sync;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   done_pulses = 0;

    inst_mem_sync_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

    inst_mem_sync #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .NOP_WORD(NOP)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents, load phase and the expected fetch port.
    logic [31:0] m_mem [64];
    int          m_mode;
    int          m_count;
    logic [31:0] e_inst;
    logic        e_valid;
    logic        e_fault;

    initial begin
        for (int i = 0; i < 64; i++) m_mem[i] = NOP;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  = 0;
            m_count = 0;
            e_inst  = NOP;
            e_valid = 1'b0;
            e_fault = 1'b0;
        end else begin : model_step
            int next_mode;
            next_mode = m_mode;
            if (bus.if_flush || m_mode != 0 || bus.ld_start) begin
                e_inst = NOP; e_valid = 1'b0; e_fault = 1'b0;
            end else if (bus.if_stall) begin
                e_inst = e_inst;
            end else if (!bus.if_req) begin
                e_inst = NOP; e_valid = 1'b0; e_fault = 1'b0;
            end else if ((bus.if_pc % 4) != 0 || bus.if_pc >= 32'd256) begin
                e_inst = NOP; e_valid = 1'b1; e_fault = 1'b1;
            end else begin
                e_inst = m_mem[bus.if_pc / 4]; e_valid = 1'b1; e_fault = 1'b0;
            end
            if (m_mode == 0) begin
                if (bus.ld_start) begin
                    next_mode = 1;
                    m_count   = 0;
                end
            end else if (m_mode == 1) begin
                if (bus.ld_valid) begin
                    m_mem[m_count] = bus.ld_data;
                    m_count++;
                    if (bus.ld_last || m_count == 64) next_mode = 2;
                end
            end else begin
                next_mode = 0;
            end
            m_mode = next_mode;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_if_inst", bus.if_inst, e_inst);
            chk("cyc_if_valid", 32'(bus.if_valid), 32'(e_valid));
            chk("cyc_if_fault", 32'(bus.if_fault), 32'(e_fault));
            chk("cyc_if_par_err", 32'(bus.if_par_err), 32'd0);
            chk("cyc_ld_ready", 32'(bus.ld_ready), 32'(m_mode == 1));
            chk("cyc_busy", 32'(bus.busy), 32'(m_mode == 1));
            chk("cyc_ld_done", 32'(bus.ld_done), 32'(m_mode == 2));
            chk("cyc_ld_count", 32'(bus.ld_count), 32'(m_count));
            if (bus.ld_done) done_pulses++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        bus.if_req = 1'b1;
        bus.if_pc  = pc;
        step();
    endtask

    initial begin
        bus.if_req = 0; bus.if_stall = 0; bus.if_flush = 0; bus.if_pc = 0;
        bus.ld_start = 0; bus.ld_valid = 0; bus.ld_last = 0; bus.ld_data = 0;
        step();
        step();
        chk("rst_if_inst", bus.if_inst, NOP);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_ld_count", 32'(bus.ld_count), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
        rst_n = 1'b1;

        fetch(32'h0);
        chk("first_inst", bus.if_inst, 32'h00000013);
        chk("first_valid", 32'(bus.if_valid), 32'd1);
        chk("first_fault", 32'(bus.if_fault), 32'd0);

        bus.if_req = 0; bus.ld_start = 1;
        step();
        bus.ld_start = 0; bus.ld_valid = 1; bus.ld_data = 32'h00500093;
        step();
        bus.ld_data = 32'h00500113; bus.ld_last = 1;
        step();
        bus.ld_valid = 0; bus.ld_last = 0;
        chk("load_done", 32'(bus.ld_done), 32'd1);
        chk("load_count", 32'(bus.ld_count), 32'd2);
        step();
        chk("load_done_pulse", 32'(bus.ld_done), 32'd0);

        fetch(32'h4);
        chk("fetch_pc4", bus.if_inst, 32'h00500113);
        fetch(32'h0);
        chk("fetch_pc0", bus.if_inst, 32'h00500093);
        bus.if_stall = 1; bus.if_pc = 32'h8;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_inst", bus.if_inst, 32'h00500093);
            chk("stall_valid", 32'(bus.if_valid), 32'd1);
        end
        bus.if_flush = 1;
        step();
        chk("flush_valid", 32'(bus.if_valid), 32'd0);
        chk("flush_inst", bus.if_inst, NOP);
        bus.if_flush = 0; bus.if_stall = 0;

        fetch(32'h2);
        chk("misalign_fault", 32'(bus.if_fault), 32'd1);
        chk("misalign_inst", bus.if_inst, NOP);
        fetch(32'h100);
        chk("range_fault", 32'(bus.if_fault), 32'd1);
        fetch(32'h0);
        chk("fault_clears", 32'(bus.if_fault), 32'd0);

        bus.if_req = 0; bus.ld_start = 1;
        step();
        bus.ld_start = 0; bus.ld_valid = 1;
        for (int i = 0; i < 64; i++) begin
            bus.ld_data = 32'h10000000 + 32'(i);
            step();
        end
        chk("full_count", 32'(bus.ld_count), 32'd64);
        chk("full_done", 32'(bus.ld_done), 32'd1);
        bus.ld_data = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_no_ready", 32'(bus.ld_ready), 32'd0);
            chk("full_count_hold", 32'(bus.ld_count), 32'd64);
        end
        bus.ld_valid = 0;
        fetch(32'd252);
        chk("full_top_word", bus.if_inst, 32'h1000003F);
        fetch(32'h0);
        chk("full_word0_kept", bus.if_inst, 32'h10000000);

        bus.if_req = 0; bus.ld_start = 1;
        step();
        bus.ld_start = 0; bus.ld_valid = 1;
        for (int i = 0; i < 3; i++) begin
            bus.ld_data = 32'hAAAA0000 + 32'(i);
            step();
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_ready", 32'(bus.ld_ready), 32'd0);
        bus.ld_valid = 0;
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("midrst_no_done", 32'(done_pulses), 32'd2);
        for (int i = 0; i < 3; i++) begin
            fetch(32'(4 * i));
            chk("midrst_new_word", bus.if_inst, 32'hAAAA0000 + 32'(i));
        end
        fetch(32'd12);
        chk("midrst_old_word", bus.if_inst, 32'h10000003);
        bus.if_req = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_mem_sync.md
Name: inst_mem_sync

Overview:
- Parametrised, synchronous-read instruction memory for the pipelined RV32I core; feeds the IF/ID stage.
- Registered fetch port with stall/flush handling and fault reporting for misaligned or out-of-range PCs.
- Sequential program-load port (valid/ready) replaces file-based preloading; a small FSM arbitrates between load and fetch.

Parameters:
- ADDR_WIDTH, 6, word-index width; DEPTH = 2**ADDR_WIDTH words
- DATA_WIDTH, 32, instruction word width
- NOP_WORD, 32'h00000013, bubble value (addi x0,x0,0)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- if_req  input  1  fetch request
- if_stall  input  1  hold fetch output
- if_flush  input  1  squash next output
- if_pc  input  32  byte address
- if_inst  output  DATA_WIDTH  fetched instruction
- if_valid  output  1  if_inst valid
- if_fault  output  1  misaligned or out-of-range fetch
- if_par_err  output  1  parity mismatch (see Optional Feature)
- ld_start  input  1  begin program load
- ld_valid  input  1  load word valid
- ld_last  input  1  final load word
- ld_data  input  DATA_WIDTH  load word
- ld_ready  output  1  load port ready
- ld_done  output  1  one-cycle load-complete pulse
- ld_count  output  ADDR_WIDTH+1  words written in last/current load
- busy  output  1  load in progress

Behaviour:
- Reset (async, rst_n=0): if_inst=NOP_WORD, if_valid=0, if_fault=0, if_par_err=0, ld_ready=0, ld_done=0, ld_count=0, busy=0, state=IDLE. Memory array is not reset. Simulation initial block fills the array with NOP_WORD.
- FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD on ld_start; ld_count cleared.
  - LOAD -> DONE when a word is accepted with ld_last=1, or the word written at index DEPTH-1 is accepted.
  - DONE -> IDLE unconditionally after one cycle.
- Outputs by state:
  - LOAD: ld_ready=1, busy=1.
  - DONE: ld_done=1, busy=0.
  - All other states: ld_ready=0.
- Load handshake: a word is written to mem[ld_count] when ld_valid && ld_ready; ld_count increments by 1 on each write.
  - ld_count holds its final value until the next ld_start.
  - ld_start outside IDLE is ignored.
- Fetch address decode: index = if_pc[ADDR_WIDTH+1:2].
- Fetch latency: 1 cycle. Applies only in IDLE with if_req=1 and if_stall=0; the next cycle gives if_inst=mem[index] and if_valid=1.
- Fault:
  - Condition: if_pc[1:0]!=0, or if_pc[31:ADDR_WIDTH+2]!=0.
  - Response: next cycle if_inst=NOP_WORD, if_valid=1, if_fault=1.
  - if_fault is not sticky; it is recomputed on every accepted fetch.
- if_req=0 (no stall, no flush): next cycle if_valid=0, if_inst=NOP_WORD.
- Priority per cycle: flush > stall > fetch.
  - Flush: next cycle if_inst=NOP_WORD, if_valid=0, if_fault=0, regardless of stall or if_req.
  - Stall: if_inst, if_valid and if_fault hold their values.
- During LOAD and DONE, fetch is ignored: if_valid=0, if_inst=NOP_WORD.
- ld_start and if_req in the same IDLE cycle: load wins and the fetch is dropped.
- Reset mid-load: returns to IDLE. Words already written remain in memory; no ld_done pulse.
- ld_count never exceeds DEPTH; no address wrap.

Optional Feature:
- Macro: INSTMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit (^ld_data) computed at load.
  - Each accepted fetch recomputes parity. On mismatch, the next cycle gives if_par_err=1, if_fault=1, if_inst=NOP_WORD, if_valid=1.
  - Words present from the simulation initial fill carry correct parity.
- Undefined: no parity storage; if_par_err is tied to 0.

Test Plan:
- Reset and first fetch: reset, then if_req=1, if_pc=0 -> one cycle later if_inst=32'h00000013, if_valid=1, if_fault=0.
- Load and fetch:
  - Stimulus: ld_start; load 32'h00500093, 32'h00500113 (ld_last on the second).
  - Load response: ld_done pulses once; ld_count=2.
  - Fetch response: if_pc=4 returns 32'h00500113 after 1 cycle.
- Stall/flush:
  - Fetch pc=0, then assert if_stall for 3 cycles -> if_inst holds 32'h00500093, if_valid=1.
  - if_flush together with if_stall -> next cycle if_valid=0, if_inst=NOP_WORD.
- Faults:
  - if_pc=32'h2 -> if_fault=1, if_inst=NOP_WORD.
  - if_pc=32'h100 (DEPTH=64) -> if_fault=1.
- Load boundary:
  - Load 64 words without ld_last -> auto DONE after index 63, ld_count=64.
  - ld_valid held afterwards -> no further writes, ld_ready=0.
- Reset mid-load: rst_n=0 after 3 words -> busy=0, ld_done never pulses, mem[0..2] keep the new values.
